// File: rtl/reorderbuf_gen_if.sv
// Dispatch, finish and commit bundle of the reorder buffer.
// Master drives dispatch/finish/flush; slave (the ROB) drives commit/status.
interface reorderbuf_gen_if #(
    parameter int DEPTH    = 64,
    parameter int DP_WIDTH = 2,
    parameter int CM_WIDTH = 2,
    parameter int NFIN     = 4,
    parameter int REGW     = 5,
    parameter int ADDRW    = 32,
    parameter int BHRW     = 10
);
    localparam int AW  = $clog2(DEPTH);
    localparam int DPW = $clog2(DP_WIDTH) + 1;
    localparam int CMW = $clog2(CM_WIDTH) + 1;

    logic [DPW-1:0]            dp_num;
    logic [DP_WIDTH*ADDRW-1:0] dp_pc;
    logic [DP_WIDTH*REGW-1:0]  dp_dst;
    logic [DP_WIDTH-1:0]       dp_dstvalid;
    logic [DP_WIDTH-1:0]       dp_store;
    logic [DP_WIDTH-1:0]       dp_branch;
    logic [DP_WIDTH*BHRW-1:0]  dp_bhr;
    logic                      dp_ready;
    logic [AW-1:0]             dp_tag;

    logic [NFIN-1:0]           fin_valid;
    logic [NFIN*AW-1:0]        fin_tag;
    logic                      br_fin;
    logic [AW-1:0]             br_tag;
    logic                      br_cond;
    logic [ADDRW-1:0]          br_jmpaddr;
    logic                      flush;

    logic [CM_WIDTH-1:0]       com_valid;
    logic [CM_WIDTH-1:0]       com_arfwe;
    logic [CM_WIDTH*REGW-1:0]  com_dst;
    logic [AW-1:0]             com_head;
    logic [CMW-1:0]            com_num;
    logic                      stcommit;
    logic                      combranch;
    logic [ADDRW-1:0]          pc_combranch;
    logic [BHRW-1:0]           bhr_combranch;
    logic                      brcond_combranch;
    logic [ADDRW-1:0]          jmpaddr_combranch;
    logic [AW:0]               count;
    logic                      empty;
    logic                      full;

    modport master (
        output dp_num, dp_pc, dp_dst, dp_dstvalid,
        output dp_store, dp_branch, dp_bhr,
        input  dp_ready, dp_tag,
        output fin_valid, fin_tag,
        output br_fin, br_tag, br_cond, br_jmpaddr,
        output flush,
        input  com_valid, com_arfwe, com_dst,
        input  com_head, com_num,
        input  stcommit, combranch,
        input  pc_combranch, bhr_combranch,
        input  brcond_combranch, jmpaddr_combranch,
        input  count, empty, full
    );

    modport slave (
        input  dp_num, dp_pc, dp_dst, dp_dstvalid,
        input  dp_store, dp_branch, dp_bhr,
        output dp_ready, dp_tag,
        input  fin_valid, fin_tag,
        input  br_fin, br_tag, br_cond, br_jmpaddr,
        input  flush,
        output com_valid, com_arfwe, com_dst,
        output com_head, com_num,
        output stcommit, combranch,
        output pc_combranch, bhr_combranch,
        output brcond_combranch, jmpaddr_combranch,
        output count, empty, full
    );
endinterface

// File: rtl/reorderbuf_gen.sv
// Circular reorder buffer: multi-lane dispatch, out-of-order finish, in-order commit.
// Define ROB_STATS_EN to add stat_committed / stat_stall counters.
module reorderbuf_gen #(
    parameter int DEPTH    = 64,
    parameter int DP_WIDTH = 2,
    parameter int CM_WIDTH = 2,
    parameter int NFIN     = 4,
    parameter int REGW     = 5,
    parameter int ADDRW    = 32,
    parameter int BHRW     = 10
) (
    input  logic clk,
    input  logic reset,
    reorderbuf_gen_if.slave bus
`ifdef ROB_STATS_EN
    ,
    output logic [31:0] stat_committed,
    output logic [31:0] stat_stall
`endif
);
    localparam int AW  = $clog2(DEPTH);
    localparam int DPW = $clog2(DP_WIDTH) + 1;
    localparam int CMW = $clog2(CM_WIDTH) + 1;

    logic [ADDRW-1:0] r_pc   [DEPTH];
    logic [REGW-1:0]  r_dst  [DEPTH];
    logic [BHRW-1:0]  r_bhr  [DEPTH];
    logic [ADDRW-1:0] r_jmp  [DEPTH];
    logic [DEPTH-1:0] r_dstvalid;
    logic [DEPTH-1:0] r_store;
    logic [DEPTH-1:0] r_branch;
    logic [DEPTH-1:0] r_finish;
    logic [DEPTH-1:0] r_brcond;
    logic [AW-1:0]    r_head;
    logic [AW-1:0]    r_tail;
    logic [AW:0]      r_count;

    logic                     w_dp_ready;
    logic                     w_dp_acc;
    logic [DPW-1:0]           w_dp_n;
    logic [CM_WIDTH-1:0]      w_cv;
    logic [CM_WIDTH-1:0]      w_arfwe;
    logic [CM_WIDTH*REGW-1:0] w_cdst;
    logic [CMW-1:0]           w_cnum;
    logic                     w_st;
    logic                     w_br;
    logic [ADDRW-1:0]         w_brpc;
    logic [BHRW-1:0]          w_brbhr;
    logic                     w_brcond;
    logic [ADDRW-1:0]         w_brjmp;
    logic                     w_ok;
    logic [AW-1:0]            w_idx;

    assign w_dp_ready = r_count <= (AW+1)'(DEPTH - DP_WIDTH);
    assign w_dp_acc   = w_dp_ready & ~bus.flush;
    assign w_dp_n     = w_dp_acc ? bus.dp_num : '0;

    // Commit chain: a slot retires only behind a retiring non-store, non-branch slot.
    always_comb begin
        w_cv     = '0;
        w_arfwe  = '0;
        w_cdst   = '0;
        w_cnum   = '0;
        w_st     = 1'b0;
        w_br     = 1'b0;
        w_brpc   = '0;
        w_brbhr  = '0;
        w_brcond = 1'b0;
        w_brjmp  = '0;
        w_idx    = r_head;
        w_ok     = ~bus.flush;
        for (int i = 0; i < CM_WIDTH; i++) begin
            w_idx    = r_head + AW'(i);
            w_cv[i]  = w_ok & ((AW+1)'(i) < r_count) & r_finish[w_idx];
            w_ok     = w_cv[i] & ~r_store[w_idx] & ~r_branch[w_idx];
            w_arfwe[i] = w_cv[i] & r_dstvalid[w_idx];
            w_cdst[i*REGW +: REGW] = r_dst[w_idx];
            w_cnum   = w_cnum + CMW'(w_cv[i]);
            if (w_cv[i] & r_store[w_idx]) begin
                w_st = 1'b1;
            end
            if (w_cv[i] & r_branch[w_idx] & ~w_br) begin
                w_br     = 1'b1;
                w_brpc   = r_pc[w_idx];
                w_brbhr  = r_bhr[w_idx];
                w_brcond = r_brcond[w_idx];
                w_brjmp  = r_jmp[w_idx];
            end
        end
    end

    // Pointer, occupancy and finish state; dispatch clear is last so it wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
            r_finish <= '0;
            r_brcond <= '0;
        end else if (bus.flush) begin
            r_tail   <= r_head;
            r_count  <= '0;
            r_finish <= '0;
        end else begin
            r_head  <= r_head + AW'(w_cnum);
            r_tail  <= r_tail + AW'(w_dp_n);
            r_count <= r_count + (AW+1)'(w_dp_n) - (AW+1)'(w_cnum);
            for (int j = 0; j < NFIN; j++) begin
                if (bus.fin_valid[j]) begin
                    r_finish[bus.fin_tag[j*AW +: AW]] <= 1'b1;
                end
            end
            if (bus.br_fin) begin
                r_finish[bus.br_tag] <= 1'b1;
                r_brcond[bus.br_tag] <= bus.br_cond;
            end
            for (int k = 0; k < DP_WIDTH; k++) begin
                if (DPW'(k) < w_dp_n) begin
                    r_finish[r_tail + AW'(k)] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (bus.br_fin) begin
            r_jmp[bus.br_tag] <= bus.br_jmpaddr;
        end
        for (int k = 0; k < DP_WIDTH; k++) begin
            if (DPW'(k) < w_dp_n) begin
                r_pc[r_tail + AW'(k)]       <= bus.dp_pc[k*ADDRW +: ADDRW];
                r_dst[r_tail + AW'(k)]      <= bus.dp_dst[k*REGW +: REGW];
                r_bhr[r_tail + AW'(k)]      <= bus.dp_bhr[k*BHRW +: BHRW];
                r_dstvalid[r_tail + AW'(k)] <= bus.dp_dstvalid[k];
                r_store[r_tail + AW'(k)]    <= bus.dp_store[k];
                r_branch[r_tail + AW'(k)]   <= bus.dp_branch[k];
            end
        end
    end

    assign bus.dp_ready          = w_dp_ready;
    assign bus.dp_tag            = r_tail;
    assign bus.com_valid         = w_cv;
    assign bus.com_arfwe         = w_arfwe;
    assign bus.com_dst           = w_cdst;
    assign bus.com_head          = r_head;
    assign bus.com_num           = w_cnum;
    assign bus.stcommit          = w_st;
    assign bus.combranch         = w_br;
    assign bus.pc_combranch      = w_brpc;
    assign bus.bhr_combranch     = w_brbhr;
    assign bus.brcond_combranch  = w_brcond;
    assign bus.jmpaddr_combranch = w_brjmp;
    assign bus.count             = r_count;
    assign bus.empty             = (r_count == '0);
    assign bus.full              = (r_count == (AW+1)'(DEPTH));

`ifdef ROB_STATS_EN
    logic [31:0] r_stat_com;
    logic [31:0] r_stat_stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stat_com   <= '0;
            r_stat_stall <= '0;
        end else begin
            r_stat_com <= r_stat_com + 32'(w_cnum);
            if ((r_count != '0) && (w_cnum == '0)) begin
                r_stat_stall <= r_stat_stall + 32'd1;
            end
        end
    end

    assign stat_committed = r_stat_com;
    assign stat_stall     = r_stat_stall;
`endif
endmodule

// File: tb/tb_reorderbuf_gen.sv
// Randomized bench for reorderbuf_gen against a queue-based ROB model.
// Directed scenarios first, then random dispatch/finish/flush traffic.
module tb_reorderbuf_gen;
    localparam int DEPTH = 8;
    localparam int DP    = 2;
    localparam int CM    = 2;
    localparam int NF    = 2;
    localparam int RW    = 5;
    localparam int ADW   = 32;
    localparam int BW    = 10;
    localparam int AW    = 3;

    typedef struct {
        int          tag;
        logic [4:0]  dst;
        logic        dv;
        logic        st;
        logic        br;
        logic [31:0] pc;
        logic [9:0]  bhr;
        logic        fin;
        logic        cond;
        logic [31:0] jmp;
    } ent_t;

    logic clk = 1'b0;
    logic reset;
    ent_t q[$];
    int   mhead;
    int   nchk;
    int   nerr;
    int   m_com;
    int   m_stall;

    always #5 clk = ~clk;

    reorderbuf_gen_if #(
        .DEPTH(DEPTH), .DP_WIDTH(DP), .CM_WIDTH(CM), .NFIN(NF),
        .REGW(RW), .ADDRW(ADW), .BHRW(BW)
    ) bus ();

`ifdef ROB_STATS_EN
    logic [31:0] stat_committed;
    logic [31:0] stat_stall;
`endif

    reorderbuf_gen #(
        .DEPTH(DEPTH), .DP_WIDTH(DP), .CM_WIDTH(CM), .NFIN(NF),
        .REGW(RW), .ADDRW(ADW), .BHRW(BW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
`ifdef ROB_STATS_EN
        ,
        .stat_committed(stat_committed),
        .stat_stall(stat_stall)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.dp_num      = '0;
        bus.dp_pc       = '0;
        bus.dp_dst      = '0;
        bus.dp_dstvalid = '0;
        bus.dp_store    = '0;
        bus.dp_branch   = '0;
        bus.dp_bhr      = '0;
        bus.fin_valid   = '0;
        bus.fin_tag     = '0;
        bus.br_fin      = 1'b0;
        bus.br_tag      = '0;
        bus.br_cond     = 1'b0;
        bus.br_jmpaddr  = '0;
        bus.flush       = 1'b0;
    endtask

    task automatic lane(input int k, input logic [4:0] d, input logic dv,
                        input logic st, input logic br);
        bus.dp_dst[k*RW +: RW]   = d;
        bus.dp_dstvalid[k]       = dv;
        bus.dp_store[k]          = st;
        bus.dp_branch[k]         = br;
        bus.dp_pc[k*ADW +: ADW]  = $urandom;
        bus.dp_bhr[k*BW +: BW]   = 10'($urandom);
    endtask

    task automatic fin(input int j, input int t);
        bus.fin_valid[j]         = 1'b1;
        bus.fin_tag[j*AW +: AW]  = t[2:0];
    endtask

    function automatic int exp_n();
        int n = 0;
        if (bus.flush) return 0;
        for (int i = 0; i < CM && i < q.size(); i++) begin
            if (!q[i].fin) break;
            if (i > 0 && (q[i-1].st || q[i-1].br)) break;
            n++;
        end
        return n;
    endfunction

    // Check all outputs against the model, then advance one clock.
    task automatic step();
        int   n;
        int   bi;
        bit   acc;
        bit   sb;
        logic [CM-1:0] wmask;
        ent_t e;
        #1;
        chk("count", bus.count, q.size());
        chk("empty", bus.empty, q.size() == 0);
        chk("full", bus.full, q.size() == DEPTH);
        chk("dp_ready", bus.dp_ready, q.size() <= DEPTH - DP);
        chk("dp_tag", bus.dp_tag, (mhead + q.size()) % DEPTH);
        chk("com_head", bus.com_head, mhead);
        n = exp_n();
        chk("com_num", bus.com_num, n);
        chk("com_valid", bus.com_valid, (1 << n) - 1);
        wmask = '0;
        sb    = 1'b0;
        bi    = -1;
        for (int i = 0; i < n; i++) begin
            chk("com_dst", bus.com_dst[i*RW +: RW], q[i].dst);
            if (q[i].dv) wmask[i] = 1'b1;
            if (q[i].st) sb = 1'b1;
            if (q[i].br && bi < 0) bi = i;
        end
        chk("com_arfwe", bus.com_arfwe, wmask);
        chk("stcommit", bus.stcommit, sb);
        chk("combranch", bus.combranch, bi >= 0);
        if (bi >= 0) begin
            chk("pc_combranch", bus.pc_combranch, q[bi].pc);
            chk("bhr_combranch", bus.bhr_combranch, q[bi].bhr);
            chk("brcond_combranch", bus.brcond_combranch, q[bi].cond);
            chk("jmpaddr_combranch", bus.jmpaddr_combranch, q[bi].jmp);
        end
        m_com += n;
        if (q.size() > 0 && n == 0) m_stall++;
        acc = (q.size() <= DEPTH - DP) && !bus.flush;
        @(posedge clk);
        if (bus.flush) begin
            q.delete();
        end else begin
            for (int j = 0; j < NF; j++) begin
                if (bus.fin_valid[j]) begin
                    foreach (q[i]) begin
                        if (q[i].tag == int'(bus.fin_tag[j*AW +: AW]))
                            q[i].fin = 1'b1;
                    end
                end
            end
            if (bus.br_fin) begin
                foreach (q[i]) begin
                    if (q[i].tag == int'(bus.br_tag)) begin
                        q[i].fin  = 1'b1;
                        q[i].cond = bus.br_cond;
                        q[i].jmp  = bus.br_jmpaddr;
                    end
                end
            end
            repeat (n) void'(q.pop_front());
            mhead = (mhead + n) % DEPTH;
            if (acc) begin
                for (int k = 0; k < int'(bus.dp_num); k++) begin
                    e.tag  = (mhead + q.size()) % DEPTH;
                    e.dst  = bus.dp_dst[k*RW +: RW];
                    e.dv   = bus.dp_dstvalid[k];
                    e.st   = bus.dp_store[k];
                    e.br   = bus.dp_branch[k];
                    e.pc   = bus.dp_pc[k*ADW +: ADW];
                    e.bhr  = bus.dp_bhr[k*BW +: BW];
                    e.fin  = 1'b0;
                    e.cond = 1'b0;
                    e.jmp  = '0;
                    q.push_back(e);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic rand_cycle();
        int cand[$];
        int t;
        int r;
        idle();
        if ($urandom_range(0, 29) == 0) bus.flush = 1'b1;
        bus.dp_num = 2'($urandom_range(0, DP));
        for (int k = 0; k < DP; k++) begin
            lane(k, 5'($urandom), 1'($urandom),
                 $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0);
        end
        for (int j = 0; j < NF; j++) begin
            r = $urandom_range(0, 3);
            cand.delete();
            foreach (q[i]) if (!q[i].fin && !q[i].br) cand.push_back(i);
            if (r < 2 && cand.size() > 0) begin
                fin(j, q[cand[$urandom_range(0, cand.size() - 1)]].tag);
            end else if (r == 2) begin
                t = $urandom_range(0, DEPTH - 1);
                if (((t - mhead + DEPTH) % DEPTH) >= q.size()) fin(j, t);
            end
        end
        cand.delete();
        foreach (q[i]) if (!q[i].fin && q[i].br) cand.push_back(i);
        if ($urandom_range(0, 1) == 1 && cand.size() > 0) begin
            t = q[cand[$urandom_range(0, cand.size() - 1)]].tag;
            bus.br_fin     = 1'b1;
            bus.br_tag     = t[2:0];
            bus.br_cond    = 1'($urandom);
            bus.br_jmpaddr = $urandom;
        end
        step();
    endtask

    initial begin
        nchk    = 0;
        nerr    = 0;
        mhead   = 0;
        m_com   = 0;
        m_stall = 0;
        idle();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_count", bus.count, 0);
        chk("rst_empty", bus.empty, 1);
        chk("rst_ready", bus.dp_ready, 1);
        chk("rst_com_valid", bus.com_valid, 0);
        chk("rst_stcommit", bus.stcommit, 0);
        chk("rst_combranch", bus.combranch, 0);
        chk("rst_pc_combranch", bus.pc_combranch, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // two-lane dispatch, finish both, both retire together
        idle(); bus.dp_num = 2; lane(0, 3, 1, 0, 0); lane(1, 4, 1, 0, 0); step();
        idle(); fin(0, 0); fin(1, 1); step();
        idle(); #1 chk("t1_com_num", bus.com_num, 2); step();
        #1 chk("t1_head", bus.com_head, 2); chk("t1_count", bus.count, 0);

        // store at slot0 blocks slot1 for one cycle
        idle(); bus.dp_num = 2; lane(0, 7, 0, 1, 0); lane(1, 8, 1, 0, 0); step();
        idle(); fin(0, 2); fin(1, 3); step();
        idle(); #1 chk("t2_num0", bus.com_num, 1); chk("t2_st0", bus.stcommit, 1); step();
        idle(); #1 chk("t2_num1", bus.com_num, 1); chk("t2_st1", bus.stcommit, 0); step();

        // dispatch and finish same tag: dispatch wins
        idle(); bus.dp_num = 1; lane(0, 9, 1, 0, 0); fin(0, 4); step();
        idle(); #1 chk("t3_nocommit", bus.com_num, 0); chk("t3_count", bus.count, 1); step();
        idle(); fin(0, 4); step();
        idle(); #1 chk("t3_commit", bus.com_num, 1); step();
        idle(); bus.dp_num = 1; lane(0, 10, 1, 0, 0); step();
        idle(); fin(0, 5); step();
        idle(); step();

        // fill to full from head=6, extra dispatch ignored
        for (int c = 0; c < 4; c++) begin
            idle(); bus.dp_num = 2;
            lane(0, 5'(c * 2 + 11), 1, 0, 0); lane(1, 5'(c * 2 + 12), 1, 0, 0);
            step();
        end
        #1 chk("t4_full", bus.full, 1); chk("t4_ready", bus.dp_ready, 0);
        idle(); bus.dp_num = 2; lane(0, 1, 1, 0, 0); lane(1, 2, 1, 0, 0); step();
        #1 chk("t4_hold", bus.count, 8);

        // wrap: 6,7,0,1 retire in order, head lands on 2
        idle(); fin(0, 6); fin(1, 7); step();
        idle(); fin(0, 0); fin(1, 1); step();
        idle(); step();
        #1 chk("t5_head", bus.com_head, 2); chk("t5_count", bus.count, 4);

        // flush with count=5 and two finished at head
        idle(); bus.dp_num = 1; lane(0, 20, 1, 0, 0); step();
        idle(); fin(0, 2); fin(1, 3); step();
        idle(); bus.flush = 1'b1;
        #1 chk("t6_num", bus.com_num, 0); chk("t6_cnt5", bus.count, 5); step();
        idle(); #1 chk("t6_count", bus.count, 0); chk("t6_tail", bus.dp_tag, 2); step();

        repeat (3000) rand_cycle();

        // reset in the middle of traffic
        idle(); bus.dp_num = 2; lane(0, 1, 1, 0, 0); lane(1, 2, 1, 0, 0); step();
        idle(); #2 reset = 1'b1;
        #1 chk("mr_count", bus.count, 0); chk("mr_head", bus.com_head, 0);
        chk("mr_tag", bus.dp_tag, 0); chk("mr_ready", bus.dp_ready, 1);
        chk("mr_com_num", bus.com_num, 0);
        @(negedge clk);
        reset = 1'b0;
        q.delete();
        mhead   = 0;
        m_com   = 0;
        m_stall = 0;
        repeat (500) rand_cycle();

`ifdef ROB_STATS_EN
        chk("stat_committed", stat_committed, m_com);
        chk("stat_stall", stat_stall, m_stall);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
        $finish;
    end
endmodule

// File: doc/reorderbuf_gen.md
REORDERBUF_GEN -- requirements
Module: reorderbuf_gen

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning entry count; power of two, 4..256; AW = log2(DEPTH).
REQ-002 SHALL have parameter DP_WIDTH, default 2, meaning maximum dispatches per cycle, 1..4.
REQ-003 SHALL have parameter CM_WIDTH, default 2, meaning maximum commits per cycle, 1..4.
REQ-004 SHALL have parameter NFIN, default 4, meaning count of non-branch finish ports.
REQ-005 SHALL have parameters REGW, default 5, ADDRW, default 32, and BHRW, default 10, meaning register select, PC and branch-history widths.
REQ-006 SHALL have clk, in, 1, the single clock; all state updates on its rising edge.
REQ-007 SHALL have reset, in, 1, asynchronous active-high reset.
REQ-008 SHALL have dp_num, in, log2(DP_WIDTH)+1, meaning entries dispatched this cycle, packed from lane 0.
REQ-009 SHALL have dp_pc/dp_dst/dp_dstvalid/dp_store/dp_branch/dp_bhr, in, DP_WIDTH x field width each, meaning per-lane flattened entry fields.
REQ-010 SHALL have dp_ready, out, 1, meaning free >= DP_WIDTH; dp_tag, out, AW, meaning tail pointer (lane k gets tail+k mod DEPTH).
REQ-011 SHALL have fin_valid, in, NFIN, and fin_tag, in, NFIN x AW, meaning execution-done markers.
REQ-012 SHALL have br_fin, in, 1, br_tag, in, AW, br_cond, in, 1, and br_jmpaddr, in, ADDRW, meaning branch-unit done.
REQ-013 SHALL have flush, in, 1, meaning mispredict squash.
REQ-014 SHALL have com_valid, out, CM_WIDTH; com_arfwe, out, CM_WIDTH; com_dst, out, CM_WIDTH x REGW; com_head, out, AW; com_num, out, log2(CM_WIDTH)+1.
REQ-015 SHALL have stcommit, combranch, out, 1 each, and pc_/bhr_/brcond_/jmpaddr_combranch, out, field width, meaning retiring branch data.
REQ-016 SHALL have count, out, AW+1, meaning occupancy; empty and full, out, 1 each.

Function
REQ-017 SHALL accept dispatch only when dp_ready=1; dp_num is ignored otherwise.
REQ-018 SHALL write the fields of each accepted lane k into entry tail+k, clear its finish bit, and advance tail by dp_num mod DEPTH.
REQ-019 SHALL set finish[tag] on any fin_valid or br_fin; br_fin also stores br_cond and br_jmpaddr.
REQ-020 SHALL let a dispatch clear win over a finish set on the same entry in the same cycle.
REQ-021 SHALL commit slot i (entry head+i) combinationally iff: slot i-1 commits (i>0), i<count, finish set, slot i-1 is neither store nor branch, and flush=0.
REQ-022 SHALL drive com_num = number of committing slots, always a contiguous prefix.
REQ-023 SHALL drive com_arfwe[i] = com_valid[i] & dstvalid and com_dst[i] = dst of slot i.
REQ-024 SHALL assert stcommit and combranch when a committing slot is a store or a branch; branch outputs come from the lowest such slot, at most one per cycle by REQ-021.
REQ-025 SHALL advance head by com_num on the next edge; count next = count + accepted dp_num - com_num.
REQ-026 SHALL, on flush, block commit and dispatch that cycle, then next cycle set tail=head, count=0 and clear all finish bits.
REQ-027 SHALL wrap head and tail modulo DEPTH, with full = (count==DEPTH) and empty = (count==0).

Reset
REQ-028 SHALL, on reset, asynchronously set head=0, tail=0, count=0, and clear finish and brcond; all commit outputs are then 0 and dp_ready=1.
REQ-029 SHALL, on reset mid-operation, discard all in-flight entries; payload arrays are not reset.

Configuration
REQ-030 SHALL, with ROB_STATS_EN defined, add outputs stat_committed and stat_stall (32 bits, wrapping, reset 0), counting the sum of com_num and the cycles with count>0 & com_num==0 respectively.
REQ-031 SHALL, without ROB_STATS_EN, omit these ports and their logic.

Verification
REQ-032 SHALL cover: reset, dispatch 2 (dp_num=2), finish both -> cycle after finish com_num=2, head=2, count=0.
REQ-033 SHALL cover: slot0 store finished, slot1 ALU finished -> com_num=1, stcommit=1; next cycle com_num=1.
REQ-034 SHALL cover: DEPTH=8, fill to 8 -> full=1, dp_ready=0; a further dp_num=2 is ignored and count stays 8.
REQ-035 SHALL cover: head=6, tail wraps past 7 to 2 -> entries 6,7,0,1 commit in order and head=2.
REQ-036 SHALL cover: flush with count=5 and two finished at head -> com_num=0 that cycle, then count=0, tail=head.
REQ-037 SHALL cover: dispatch and finish on the same tag in one cycle -> finish=0, and the entry does not commit.
